lsu_access_sequencer: RTL
=========================

// Module: lsu_access_sequencer
// PURPOSE
// - Sequences every load/store from the MEM stage into the byte-banked data memory (odd/even byte banks).
// - Builds the word address, byte enables and lane-shifted write data; downstream bank steering only maps lanes to banks.
// - Splits accesses that cross a 4-byte word boundary into two memory beats and stalls the requester.
// - Merges load beats and sign/zero-extends them into one response.
// PARAMETERS
// - ALLOW_MISALIGNED  1  1: split word-crossing accesses; 0: reject them with o_rsp_err, no memory access
// PORTS
// - i_clk           in   1   clock, rising edge
// - i_rst_n         in   1   reset, synchronous, active-low
// - i_req_valid     in   1   request valid
// - o_req_ready     out  1   request accepted when valid&ready
// - i_req_we        in   1   1 store, 0 load
// - i_req_addr      in   32  byte address
// - i_req_size      in   2   00 byte, 01 half, 10 word; 11 reserved (rejected, o_rsp_err)
// - i_req_unsigned  in   1   load zero-extend (LBU/LHU)
// - i_req_wdata     in   32  store data, LSB-aligned
// - o_mem_req       out  1   memory beat strobe, one cycle per beat
// - o_mem_we        out  1   beat is a write
// - o_mem_addr      out  32  word-aligned address ([1:0]=0)
// - o_mem_byte_en   out  4   lane enables
// - o_mem_wdata     out  32  lane-shifted write data
// - i_mem_rdata     in   32  read word; valid the cycle after its o_mem_req
// - o_rsp_valid     out  1   one-cycle response pulse (loads and stores)
// - o_rsp_rdata     out  32  extended load data; 0 for stores/errors
// - o_rsp_err       out  1   reserved size, or misaligned with ALLOW_MISALIGNED=0
// BEHAVIOUR
// - Reset: state IDLE; o_req_ready=1; o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_byte_en=0, o_mem_wdata=0;
//   o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0. Reset mid-operation drops in-flight beats; a split store cut after
//   beat 0 leaves beat 0 written (no rollback).
// - FSM: IDLE -> ISSUE0 -> [ISSUE1 if split] -> CAPTURE -> IDLE. Error requests: IDLE -> ERR -> IDLE.
// - o_req_ready=1 only in IDLE; request fields latched on acceptance.
// - off=addr[1:0]; mask=0001/0011/1111 by size; split = (off+bytes)>4 (half at off=3; word at off!=0).
// - ISSUE0: o_mem_addr={addr[31:2],2'b00}, byte_en=(mask<<off)[3:0], wdata=(wdata64<<8*off)[31:0].
// - ISSUE1: o_mem_addr=beat0 addr+4 (wraps mod 2^32), byte_en=(mask<<off)[7:4], wdata=(...)[63:32].
// - ISSUE1 captures beat-0 i_mem_rdata; CAPTURE captures last-beat rdata.
// - Load: merged={beat1,beat0}>>8*off, lane 0 LSB; extend by size/unsigned; o_rsp_valid registered (first IDLE cycle).
// - Latency accept->o_rsp_valid: 3 cycles unsplit, 4 split, 2 for ERR. Back-to-back accept allowed in the IDLE
//   cycle carrying o_rsp_valid.
// - o_mem_* outputs are zero in every cycle with o_mem_req=0. Stores: o_rsp_rdata=0.
// STRUCTURE
// - Shared package lsu_pkg: lsu_size_e (SZ_B/SZ_H/SZ_W), lsu_seq_state_e, mask constants.
// - One sub-module lsu_load_extend: combinational merge/shift/extend of {beat1,beat0}, off, size, unsigned -> 32b.
// TESTING
// - SW 0xAABBCCDD @0x100: one beat addr 0x100, be 1111, wdata 0xAABBCCDD; rsp at accept+3, err=0.
// - SH 0x1234 @0x103: beat0 addr 0x100 be 1000 wdata 0x34000000; beat1 addr 0x104 be 0001 wdata 0x00000012.
// - LW @0x102, mem[0x100]=0x44332211, mem[0x104]=0x88776655: two beats; o_rsp_rdata=0x66554433 at accept+4.
// - LB @0x101 mem=0x0000F000 -> 0xFFFFFFF0; LBU same -> 0x000000F0; size=11 -> err=1, no o_mem_req.
// - Reset asserted in ISSUE1: next cycle IDLE, o_mem_req=0, o_rsp_valid=0, o_req_ready=1.
// - ALLOW_MISALIGNED=0, LW @0x101: no o_mem_req; o_rsp_valid+o_rsp_err at accept+2; back-to-back LW @0x200 then proceeds.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store access sequencer: access sizes, sequencer states,
// lane masks and the word-crossing test.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE0,
        ST_ISSUE1,
        ST_CAPTURE,
        ST_ERR
    } lsu_seq_state_e;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic [3:0] size_mask(input lsu_size_e size);
        case (size)
            SZ_B:    return MASK_B;
            SZ_H:    return MASK_H;
            SZ_W:    return MASK_W;
            default: return 4'b0000;
        endcase
    endfunction

    // An access needs a second beat when its bytes run past lane 3 of the first word.
    function automatic logic needs_split(input logic [1:0] off, input lsu_size_e size);
        case (size)
            SZ_H:    return off == 2'd3;
            SZ_W:    return off != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load merge: shifts the two-beat window down by the byte offset and
// sign/zero-extends the addressed byte, half or word into a 32-bit result.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [63:0] beats,
    input  logic [1:0]  off,
    input  lsu_size_e   size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] merged;

    always_comb begin
        merged = 32'(beats >> {off, 3'b000});
        data   = 32'h0;
        case (size)
            SZ_B:    data = {{24{~is_unsigned & merged[7]}}, merged[7:0]};
            SZ_H:    data = {{16{~is_unsigned & merged[15]}}, merged[15:0]};
            SZ_W:    data = merged;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_access_sequencer.sv
// Sequences MEM-stage loads/stores into the byte-banked data memory, splitting word-crossing
// accesses into two beats and merging load beats into a single extended response.
module lsu_access_sequencer
    import lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_wdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_byte_en,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    lsu_seq_state_e state_q, state_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] beat0_q;
    lsu_size_e   size_q;
    logic        we_q;
    logic        unsigned_q;
    logic        split_q;

    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic        accept;
    logic        req_err;
    logic [7:0]  be_wide;
    logic [63:0] wdata_wide;
    logic [63:0] load_beats;
    logic [31:0] load_data;
    logic [31:0] beat0_addr;

    assign accept  = i_req_valid && (state_q == ST_IDLE);
    assign req_err = (i_req_size == SZ_RSV) ||
                     (!ALLOW_MISALIGNED && needs_split(i_req_addr[1:0], lsu_size_e'(i_req_size)));

    // Lanes and data for both beats come from one 8-lane window shifted by the byte offset.
    assign be_wide    = {4'b0000, size_mask(size_q)} << addr_q[1:0];
    assign wdata_wide = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
    assign beat0_addr = {addr_q[31:2], 2'b00};
    assign load_beats = split_q ? {i_mem_rdata, beat0_q} : {32'h0, i_mem_rdata};

    lsu_load_extend u_load_extend (
        .beats       (load_beats),
        .off         (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (load_data)
    );

    always_comb begin
        state_d       = state_q;
        o_req_ready   = 1'b0;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_addr    = 32'h0;
        o_mem_byte_en = 4'b0000;
        o_mem_wdata   = 32'h0;
        case (state_q)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    state_d = req_err ? ST_ERR : ST_ISSUE0;
                end
            end
            ST_ISSUE0: begin
                o_mem_req     = 1'b1;
                o_mem_we      = we_q;
                o_mem_addr    = beat0_addr;
                o_mem_byte_en = be_wide[3:0];
                o_mem_wdata   = wdata_wide[31:0];
                state_d       = split_q ? ST_ISSUE1 : ST_CAPTURE;
            end
            ST_ISSUE1: begin
                o_mem_req     = 1'b1;
                o_mem_we      = we_q;
                o_mem_addr    = beat0_addr + 32'd4;
                o_mem_byte_en = be_wide[7:4];
                o_mem_wdata   = wdata_wide[63:32];
                state_d       = ST_CAPTURE;
            end
            ST_CAPTURE: state_d = ST_IDLE;
            ST_ERR:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            beat0_q     <= 32'h0;
            size_q      <= SZ_B;
            we_q        <= 1'b0;
            unsigned_q  <= 1'b0;
            split_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            if (accept) begin
                addr_q     <= i_req_addr;
                wdata_q    <= i_req_wdata;
                size_q     <= lsu_size_e'(i_req_size);
                we_q       <= i_req_we;
                unsigned_q <= i_req_unsigned;
                split_q    <= needs_split(i_req_addr[1:0], lsu_size_e'(i_req_size));
            end
            // Beat-0 read data arrives while beat 1 is on the bus.
            if (state_q == ST_ISSUE1) begin
                beat0_q <= i_mem_rdata;
            end
            if (state_q == ST_CAPTURE) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= we_q ? 32'h0 : load_data;
            end
            if (state_q == ST_ERR) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
            end
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;

endmodule
